// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its multi-cycle operand/result sequencer.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 16;

    localparam logic [SEL_WIDTH-1:0] OP_AND  = 16'd0;
    localparam logic [SEL_WIDTH-1:0] OP_OR   = 16'd1;
    localparam logic [SEL_WIDTH-1:0] OP_NOT  = 16'd2;
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = 16'd3;
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = 16'd4;
    localparam logic [SEL_WIDTH-1:0] OP_NEG  = 16'd5;
    localparam logic [SEL_WIDTH-1:0] OP_ROL  = 16'd6;
    localparam logic [SEL_WIDTH-1:0] OP_ROR  = 16'd7;
    localparam logic [SEL_WIDTH-1:0] OP_SHL  = 16'd8;
    localparam logic [SEL_WIDTH-1:0] OP_SHR  = 16'd9;
    localparam logic [SEL_WIDTH-1:0] OP_SHRA = 16'd10;
    localparam logic [SEL_WIDTH-1:0] OP_ADD  = 16'd11;
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = 16'd12;
    localparam logic [SEL_WIDTH-1:0] OP_MUL  = 16'd13;
    localparam logic [SEL_WIDTH-1:0] OP_DIV  = 16'd14;
    localparam logic [SEL_WIDTH-1:0] OP_MAX  = 16'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_B,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic op_legal(input logic [SEL_WIDTH-1:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control-side request/result signals plus the ALU operand/result path of the sequencer.
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic                  start;
    logic [SEL_WIDTH-1:0]  op;
    logic [DATA_WIDTH-1:0] bus_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [SEL_WIDTH-1:0]  alu_sel;
    logic [DATA_WIDTH-1:0] alu_zhigh;
    logic [DATA_WIDTH-1:0] alu_zlow;

    modport master (
        output start, op, bus_in,
        input  busy, done, err, result, hi, lo
    );

    modport slave (
        input  start, op, bus_in, alu_zhigh, alu_zlow,
        output busy, done, err, result, hi, lo, alu_a, alu_b, alu_sel
    );

    modport alu (
        input  alu_a, alu_b, alu_sel,
        output alu_zhigh, alu_zlow
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: 64-bit ZHigh/ZLow result, zero for unknown selects.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [DATA_WIDTH-1:0] zhigh,
    output logic [DATA_WIDTH-1:0] zlow
);

    logic [$clog2(DATA_WIDTH)-1:0]   sh;
    logic signed [2*DATA_WIDTH-1:0]  a_wide;
    logic signed [2*DATA_WIDTH-1:0]  b_wide;
    logic signed [DATA_WIDTH:0]      a_ext;
    logic signed [DATA_WIDTH:0]      b_ext;

    always_comb begin
        zhigh  = '0;
        zlow   = '0;
        sh     = b[$clog2(DATA_WIDTH)-1:0];
        a_wide = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        b_wide = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        // one extra bit keeps most-negative / -1 well defined
        a_ext  = {a[DATA_WIDTH-1], a};
        b_ext  = {b[DATA_WIDTH-1], b};
        case (sel)
            OP_AND:  zlow = a & b;
            OP_OR:   zlow = a | b;
            OP_NOT:  zlow = ~a;
            OP_XOR:  zlow = a ^ b;
            OP_NOR:  zlow = ~(a | b);
            OP_NEG:  zlow = -a;
            OP_ROL:  zlow = (a << sh) | (a >> (DATA_WIDTH - int'(sh)));
            OP_ROR:  zlow = (a >> sh) | (a << (DATA_WIDTH - int'(sh)));
            OP_SHL:  zlow = a << sh;
            OP_SHR:  zlow = a >> sh;
            OP_SHRA: zlow = $signed(a) >>> sh;
            OP_ADD:  zlow = a + b;
            OP_SUB:  zlow = a - b;
            OP_MUL:  {zhigh, zlow} = a_wide * b_wide;
            OP_DIV: begin
                if (b != '0) begin
                    zlow  = DATA_WIDTH'(a_ext / b_ext);
                    zhigh = DATA_WIDTH'(a_ext % b_ext);
                end
            end
            default: begin
                zhigh = '0;
                zlow  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle front end: gathers two operands off the shared bus, runs the ALU
// for one cycle, and writes back result (and HI/LO for mul/div).
//
// state    | meaning
// ST_IDLE  | waiting for start; operand A and op captured on start
// ST_GET_B | operand B captured from the bus
// ST_EXEC  | ALU inputs stable; Z captured at end of cycle
// ST_WB    | result/hi/lo/err written; done pulses next cycle
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    alu_op_sequencer_if.slave  sq
);

    state_t                  state_q, state_d;
    logic                    cap_a, cap_b, cap_z, wb;
    logic [DATA_WIDTH-1:0]   y_q, b_q;
    logic [SEL_WIDTH-1:0]    opreg_q;
    logic [2*DATA_WIDTH-1:0] z_q;
    logic [DATA_WIDTH-1:0]   result_q, hi_q, lo_q;
    logic                    done_q, err_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        cap_z   = 1'b0;
        wb      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sq.start) begin
                    cap_a   = 1'b1;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                cap_b   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cap_z   = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                wb      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            y_q      <= '0;
            b_q      <= '0;
            opreg_q  <= '0;
            z_q      <= '0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (cap_a) begin
                y_q     <= sq.bus_in;
                opreg_q <= sq.op;
            end
            if (cap_b) begin
                b_q <= sq.bus_in;
            end
            if (cap_z) begin
                z_q <= {sq.alu_zhigh, sq.alu_zlow};
            end
            done_q <= wb;
            if (wb) begin
                if (op_legal(opreg_q)) begin
                    result_q <= z_q[DATA_WIDTH-1:0];
                    err_q    <= 1'b0;
                    if (opreg_q == OP_MUL || opreg_q == OP_DIV) begin
                        hi_q <= z_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        lo_q <= z_q[DATA_WIDTH-1:0];
                    end
                end else begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign sq.busy    = (state_q != ST_IDLE);
    assign sq.done    = done_q;
    assign sq.err     = err_q;
    assign sq.result  = result_q;
    assign sq.hi      = hi_q;
    assign sq.lo      = lo_q;
    assign sq.alu_a   = y_q;
    assign sq.alu_b   = b_q;
    assign sq.alu_sel = opreg_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Multi-cycle front end that drives the combinational ALU and consumes its result.
- Collects two operands from the shared data bus on consecutive cycles into internal Y and B registers, then presents A, B and ALU_Sel to the ALU.
- Captures the 64-bit ZHigh/ZLow result into an internal Z register and writes it back to a result register; for multiply/divide it also writes HI/LO.
- Sits between the control unit and the ALU instance in the CPU datapath.

## Interface
- DATA_WIDTH, 32, operand/result width
- SEL_WIDTH, 16, ALU select width (matches ALU_Sel)
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  reset; synchronous and active-high
- start  in  1  request; sampled only in IDLE
- op  in  SEL_WIDTH  operation code, sampled with start (0..14 legal)
- bus_in  in  DATA_WIDTH  operand bus: operand A on the start cycle, operand B on the following cycle
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result/hi/lo/err valid from this cycle
- err  out  1  illegal op flag, valid with done, held until next done
- result  out  DATA_WIDTH  Z low word of the last operation
- hi, lo  out  DATA_WIDTH  HI/LO registers, written only by mul (13) / div (14)
- alu_a, alu_b  out  DATA_WIDTH  ALU operands (Y register, B register)
- alu_sel  out  SEL_WIDTH  ALU select (op register)
- alu_zhigh, alu_zlow  in  DATA_WIDTH  ALU result halves

## Operation
- States: IDLE, GET_B, EXEC, WB.
- IDLE:
  - start=1 → Y<=bus_in, opreg<=op, state GET_B.
  - start=0 → stay.
- GET_B: B<=bus_in unconditionally (also for unary ops 2 and 5, where B is don't-care) → EXEC.
- EXEC: alu_a/alu_b/alu_sel are stable from registers; Z<={alu_zhigh, alu_zlow} at end of cycle → WB.
- WB, legal op:
  - result<=Z[DATA_WIDTH-1:0], done<=1, err<=0.
  - If opreg is 13 or 14: hi<=Z upper half, lo<=Z lower half, verbatim with no reinterpretation.
  - → IDLE.
- WB, illegal op (opreg>14):
  - The ALU has already produced 0.
  - result<=0, err<=1, done<=1; hi/lo unchanged.
  - → IDLE.
- start outside IDLE is ignored: no queuing, no error.
- busy is high exactly in GET_B, EXEC and WB.
- Width rules: no truncation inside the block; Z is 2*DATA_WIDTH.
- clr (any state, including mid-operation):
  - Next edge: state IDLE.
  - All registers (Y, B, opreg, Z, result, hi, lo) and done, err and busy are 0.
  - No done pulse is produced for the aborted operation.
- clr and start in the same cycle: clr wins; start is lost.

## Timing
- Cycle 0 (IDLE, start=1, bus_in=A) → cycle 1 GET_B (bus_in=B) → cycle 2 EXEC → cycle 3 WB → cycle 4: done=1, result valid, back in IDLE.
- Latency: start to done is 4 cycles.
- done is high for exactly one cycle.
- A new start is accepted in the same cycle done is high, so the issue interval is 4 cycles.
- ALU combinational path has one full cycle (EXEC) to settle; alu_* outputs do not change during EXEC.
- result/hi/lo/err hold their values until the next WB.
- Reset values of all outputs: 0.

## Structure
- Shared package alu_pkg:
  - Op code constants: AND=0, OR=1, NOT=2, XOR=3, NOR=4, NEG=5, ROL=6, ROR=7, SHL=8, SHR=9, SHRA=10, ADD=11, SUB=12, MUL=13, DIV=14.
  - OP_MAX=14.
  - State enum (2-bit).
- Single module; no sub-modules.
- The ALU is instantiated beside it by the datapath top, not inside it.
- The bench wires a real ALU instance to the alu_* ports.

## Test plan
- ADD: op=11, A=5, B=7 → done at cycle 4, result=12, err=0, hi/lo unchanged.
- SUB: op=12, A=3, B=5 → result=32'hFFFFFFFE.
- MUL signed: op=13, A=-3, B=5 → lo=32'hFFFFFFF1, hi=32'hFFFFFFFF, result=32'hFFFFFFF1.
- Illegal op: op=15, A=1, B=1 → err=1, result=0, hi/lo retain previous MUL values; following ADD clears err.
- Busy rejection and back-to-back:
  - start pulsed in GET_B/EXEC is ignored; exactly one done occurs.
  - start asserted in the done cycle begins the next op, with done 4 cycles later.
- Reset mid-op: clr in EXEC → next cycle busy=0, all outputs 0; no done pulse follows; next start completes normally.
